// File: rtl/bec_load_sequencer.sv
// bec_load_sequencer: assembles 163-bit operands from a 32-bit word stream, pushes them to a BEC core, streams the key and returns the result
module bec_load_sequencer #(
    parameter int WORDS = 6
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic         start,
    input  logic         abort,
    input  logic         in_valid,
    input  logic [31:0]  in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [31:0]  out_data,
    input  logic         out_ready,
    output logic         busy,
    output logic         done,
    output logic [2:0]   state_o,
    output logic         master_ena_proc,
    output logic         load_data,
    output logic [2:0]   load_status,
    output logic [162:0] data_out,
    output logic         trigLoad,
    output logic         ki,
    input  logic         next_key,
    input  logic         slv_done,
    input  logic [162:0] data_in
);
    typedef enum logic [2:0] {IDLE = 3'd0, LOAD = 3'd1, PUSH = 3'd2, PROC = 3'd3, READ = 3'd4, DONE = 3'd5} state_t;
    localparam logic [2:0] LAST = 3'(WORDS - 1);
    localparam int AW = 32 * WORDS;
    state_t r_state, w_state_nx;
    logic [2:0] r_op_idx, r_word_idx, r_k, r_load_status;
    logic [162:0] r_asm, r_key, r_result, w_asm_nx;
    logic [AW-1:0] w_res_ext;
    logic w_abort, w_in_fire, w_out_fire;
    assign w_abort = abort && r_state != IDLE;
    assign w_in_fire = in_valid && r_state == LOAD && !abort;
    assign w_out_fire = out_ready && r_state == READ && !abort;
    assign w_res_ext = AW'(r_result);
    assign busy = r_state != IDLE;
    assign state_o = r_state;
    genvar g;
    generate
        for (g = 0; g < 163; g++) begin : g_asm
            assign w_asm_nx[g] = (r_word_idx == 3'(g / 32)) ? in_data[g % 32] : r_asm[g];
        end
    endgenerate
    // state register
    always_ff @(posedge wb_clk_i) begin
        r_state <= wb_rst_i ? IDLE : w_state_nx;
    end
    // next-state and per-state outputs; abort overrides every transition
    always_comb begin
        w_state_nx      = r_state;
        in_ready        = 1'b0;
        out_valid       = 1'b0;
        out_data        = 32'd0;
        done            = 1'b0;
        master_ena_proc = 1'b0;
        ki              = 1'b0;
        trigLoad        = 1'b0;
        load_data       = 1'b0;
        load_status     = r_load_status;
        data_out        = 163'd0;
        case (r_state)
            IDLE: w_state_nx = start ? LOAD : IDLE;
            LOAD: begin
                in_ready = 1'b1;
                if (w_in_fire && r_word_idx == LAST)
                    w_state_nx = (r_op_idx <= 3'd5) ? PUSH : PROC;
            end
            PUSH: begin
                trigLoad    = 1'b1;
                load_data   = 1'b1;
                load_status = r_op_idx;
                data_out    = r_asm;
                w_state_nx  = LOAD;
            end
            PROC: begin
                master_ena_proc = 1'b1;
                ki              = r_key[0];
                w_state_nx      = slv_done ? READ : PROC;
            end
            READ: begin
                out_valid = 1'b1;
                out_data  = w_res_ext[{r_k, 5'b0} +: 32];
                if (w_out_fire && r_k == LAST)
                    w_state_nx = DONE;
            end
            DONE: begin
                done       = 1'b1;
                w_state_nx = IDLE;
            end
            default: w_state_nx = IDLE;
        endcase
        if (w_abort)
            w_state_nx = IDLE;
    end
    // counters, operand assembly, key shifter and result capture
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_op_idx      <= 3'd0;
            r_word_idx    <= 3'd0;
            r_k           <= 3'd0;
            r_asm         <= 163'd0;
            r_key         <= 163'd0;
            r_result      <= 163'd0;
            r_load_status <= 3'd0;
        end else if (w_abort) begin
            r_op_idx   <= 3'd0;
            r_word_idx <= 3'd0;
            r_k        <= 3'd0;
            r_asm      <= 163'd0;
            r_key      <= 163'd0;
        end else begin
            if (r_state == IDLE && start) begin
                r_op_idx   <= 3'd0;
                r_word_idx <= 3'd0;
                r_k        <= 3'd0;
            end
            if (w_in_fire) begin
                r_asm      <= w_asm_nx;
                r_word_idx <= (r_word_idx == LAST) ? 3'd0 : r_word_idx + 3'd1;
                if (r_word_idx == LAST && r_op_idx > 3'd5)
                    r_key <= w_asm_nx;
            end
            if (r_state == PUSH) begin
                r_load_status <= r_op_idx;
                r_op_idx      <= r_op_idx + 3'd1;
            end
            if (r_state == PROC) begin
                if (slv_done)
                    r_result <= data_in;
                else if (next_key)
                    r_key <= r_key >> 1;
            end
            if (w_out_fire)
                r_k <= (r_k == LAST) ? 3'd0 : r_k + 3'd1;
        end
    end
endmodule

// File: tb/tb_bec_load_sequencer.sv
// tb_bec_load_sequencer: directed self-checking bench for bec_load_sequencer
module tb_bec_load_sequencer;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0, abort = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic         next_key = 1'b0, slv_done = 1'b0;
    logic [31:0]  in_data = 32'd0;
    logic [162:0] data_in = 163'd0;
    logic         in_ready, out_valid, busy, done, master_ena_proc, load_data, trigLoad, ki;
    logic [31:0]  out_data;
    logic [2:0]   state_o, load_status;
    logic [162:0] data_out;
    int checks = 0;
    int failures = 0;
    logic [162:0] res_a5, res2, res3;
    bec_load_sequencer #(.WORDS(6)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .done(done), .state_o(state_o),
        .master_ena_proc(master_ena_proc), .load_data(load_data), .load_status(load_status),
        .data_out(data_out), .trigLoad(trigLoad), .ki(ki), .next_key(next_key),
        .slv_done(slv_done), .data_in(data_in)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [162:0] obs, input logic [162:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    function automatic logic [31:0] word(input int op, input int w, input bit kmode);
        if (kmode && op == 6)
            return (w == 0) ? 32'h0000_000B : 32'h0;
        return {8'(op), 8'(w), 16'hC0DE};
    endfunction
    function automatic logic [162:0] opval(input int op, input bit kmode);
        logic [191:0] v;
        for (int w = 0; w < 6; w++)
            v[32*w +: 32] = word(op, w, kmode);
        return v[162:0];
    endfunction
    function automatic logic [31:0] rword(input logic [162:0] r, input int k);
        logic [191:0] v;
        v = {29'b0, r};
        return v[32*k +: 32];
    endfunction
    task automatic feed_op(input int op, input bit gap, input bit kmode, input bit poke);
        for (int w = 0; w < 6; w++) begin
            if (gap) begin
                in_valid = 1'b0;
                in_data  = 32'hDEAD_BEEF;
                tick();
                chk("gap_state", state_o, 1);
            end
            in_valid = 1'b1;
            in_data  = word(op, w, kmode);
            start    = poke;
            chk("in_ready", in_ready, 1);
            tick();
            start = 1'b0;
        end
    endtask
    task automatic load_ops(input bit gap, input bit kmode, input bit poke);
        logic [162:0] kv;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_load", state_o, 1);
        for (int op = 0; op < 6; op++) begin
            feed_op(op, gap, kmode, poke);
            chk("push_state", state_o, 2);
            chk("push_trig", trigLoad, 1);
            chk("push_load_data", load_data, 1);
            chk("push_status", load_status, op);
            chk("push_data", data_out, opval(op, kmode));
            chk("push_in_ready", in_ready, 0);
            start = poke;
            tick();
            start = 1'b0;
            chk("after_push", state_o, 1);
            chk("status_hold", load_status, op);
            chk("trig_low", trigLoad, 0);
        end
        feed_op(6, gap, kmode, poke);
        in_valid = 1'b0;
        kv = opval(6, kmode);
        chk("proc_state", state_o, 3);
        chk("proc_ena", master_ena_proc, 1);
        chk("proc_ki", ki, kv[0]);
        chk("proc_data_out", data_out, 0);
    endtask
    task automatic read_out(input bit stall, input logic [162:0] res, input bit poke);
        chk("read_state", state_o, 4);
        for (int k = 0; k < 6; k++) begin
            if (stall && k == 2) begin
                out_ready = 1'b0;
                repeat (3) begin
                    chk("stall_valid", out_valid, 1);
                    chk("stall_data", out_data, rword(res, k));
                    tick();
                end
            end
            out_ready = 1'b1;
            start     = poke;
            chk("out_valid", out_valid, 1);
            chk("out_data", out_data, rword(res, k));
            tick();
            start = 1'b0;
        end
        out_ready = 1'b0;
        chk("done_pulse", done, 1);
        chk("done_state", state_o, 5);
        chk("done_valid", out_valid, 0);
        tick();
        chk("done_clear", done, 0);
        chk("idle_state", state_o, 0);
        chk("idle_busy", busy, 0);
    endtask
    initial begin
        res_a5 = {3'b101, {20{8'hA5}}};
        res2   = {3'h3, 160'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_1122_3344};
        res3   = {3'b010, {5{32'h1357_9BDF}}};
        tick();
        tick();
        chk("rst_state", state_o, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_status", load_status, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        tick();
        chk("idle_hold", state_o, 0);
        // full run
        load_ops(1'b0, 1'b0, 1'b0);
        slv_done = 1'b1;
        data_in  = res_a5;
        tick();
        slv_done = 1'b0;
        chk("proc_exit_ena", master_ena_proc, 0);
        read_out(1'b0, res_a5, 1'b0);
        // backpressure on both streams
        load_ops(1'b1, 1'b0, 1'b0);
        slv_done = 1'b1;
        data_in  = res2;
        tick();
        slv_done = 1'b0;
        read_out(1'b1, res2, 1'b0);
        // key shifting, ignored start pulses, slv_done beating next_key
        load_ops(1'b0, 1'b1, 1'b1);
        next_key = 1'b1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        chk("ki_1", ki, 1);
        chk("ki_state", state_o, 3);
        tick();
        chk("ki_2", ki, 0);
        tick();
        chk("ki_3", ki, 1);
        tick();
        chk("ki_4", ki, 0);
        slv_done = 1'b1;
        data_in  = res3;
        tick();
        slv_done = 1'b0;
        next_key = 1'b0;
        chk("ki_read", ki, 0);
        read_out(1'b0, res3, 1'b1);
        // abort at op_idx=2, word_idx=3 with a coincident word
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int op = 0; op < 2; op++) begin
            feed_op(op, 1'b0, 1'b0, 1'b0);
            chk("abort_push", state_o, 2);
            tick();
        end
        for (int w = 0; w < 3; w++) begin
            in_valid = 1'b1;
            in_data  = word(2, w, 1'b0);
            tick();
        end
        chk("pre_abort", state_o, 1);
        abort   = 1'b1;
        in_data = word(2, 3, 1'b0);
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("abort_state", state_o, 0);
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 0);
        tick();
        chk("abort_stay", state_o, 0);
        load_ops(1'b0, 1'b0, 1'b0);
        slv_done = 1'b1;
        data_in  = res_a5;
        tick();
        slv_done = 1'b0;
        read_out(1'b0, res_a5, 1'b0);
        // reset while processing
        load_ops(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("prst_state", state_o, 0);
        chk("prst_ena", master_ena_proc, 0);
        chk("prst_ki", ki, 0);
        chk("prst_status", load_status, 0);
        chk("prst_busy", busy, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bec_load_sequencer.md
BEC_LOAD_SEQUENCER -- requirements
Module: bec_load_sequencer

Interface
REQ-001 SHALL have port wb_clk_i  in  1  sole clock; all state changes on rising edge.
REQ-002 SHALL have port wb_rst_i  in  1  reset, synchronous and active-high.
REQ-003 SHALL have port start  in  1  begin a run when idle (level sampled each cycle).
REQ-004 SHALL have port abort  in  1  cancel the run in progress.
REQ-005 SHALL have ports in_valid in 1, in_data in 32, in_ready out 1: host-to-block word stream.
REQ-006 SHALL have ports out_valid out 1, out_data out 32, out_ready in 1: block-to-host result stream.
REQ-007 SHALL have ports busy out 1 (state != IDLE), done out 1 (one-cycle end pulse), state_o out 3 (current state code).
REQ-008 SHALL have BEC ports: master_ena_proc out 1, load_data out 1, load_status out 3, data_out out 163, trigLoad out 1, ki out 1, next_key in 1, slv_done in 1, data_in in 163.
REQ-009 SHALL have parameter WORDS, default 6, meaning 32-bit words per 163-bit operand.

Function
REQ-010 SHALL implement states IDLE=0, LOAD=1, PUSH=2, PROC=3, READ=4, DONE=5, driven on state_o.
REQ-011 IDLE: start=1 SHALL move to LOAD next cycle and clear op_idx and word_idx to 0; start SHALL be ignored in every other state.
REQ-012 LOAD: in_ready SHALL be 1; each cycle with in_valid&in_ready SHALL write in_data into assembly bits [32*word_idx+31 : 32*word_idx], LSW first; bits above 162 SHALL be discarded.
REQ-013 LOAD: on the accepted word with word_idx=WORDS-1, word_idx SHALL return to 0; next state SHALL be PUSH if op_idx<=5, else PROC with the assembly copied to the key register.
REQ-014 Operand order SHALL be op_idx 0..6 = w1, z1, w2, z2, inv_w0, d, key.
REQ-015 PUSH SHALL last exactly one cycle with trigLoad=1, load_data=1, load_status=op_idx, data_out=assembly[162:0]; then op_idx increments and state returns to LOAD.
REQ-016 Outside PUSH: trigLoad=0, load_data=0, data_out=0; load_status SHALL hold its last PUSH value.
REQ-017 in_ready SHALL be 0 in every state except LOAD.
REQ-018 PROC: master_ena_proc SHALL be 1 and ki=key[0]; each cycle with next_key=1 SHALL shift key right by 1 with zero fill; outside PROC ki=0 and master_ena_proc=0.
REQ-019 PROC: slv_done=1 SHALL capture data_in into the result register and move to READ next cycle; next_key in that same cycle SHALL be ignored.
REQ-020 READ: out_valid SHALL be 1 and out_data=result word k (k from 0, LSW first; word 5 carries bits [162:160] zero-extended); each out_valid&out_ready SHALL increment k; the handshake at k=WORDS-1 SHALL move to DONE.
REQ-021 out_data SHALL stay stable while out_valid=1 and out_ready=0; out_valid SHALL be 0 outside READ.
REQ-022 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-023 abort=1 in any non-IDLE state SHALL force IDLE next cycle, clearing counters, key and assembly; abort SHALL take priority over start, handshakes, next_key and slv_done.
REQ-024 An in_valid or out_ready handshake coincident with abort SHALL not be counted.

Reset
REQ-025 wb_rst_i=1 at a clock edge SHALL force IDLE and clear op_idx, word_idx, k, assembly, key, result and load_status to 0, with priority over abort and start.
REQ-026 During and after reset, every output SHALL be 0 (state_o=0, busy=0, in_ready=0, out_valid=0, data_out=0) until start is accepted.

Verification
REQ-027 Full run: start; 42 words with in_valid held 1; slv_done pulse with data_in=163'h5_A5A5...A5 -> 6 PUSH pulses with load_status 0..5; 6 out words, word5=32'h5; done for 1 cycle.
REQ-028 Backpressure: in_valid toggled 1/0 and out_ready held 0 for 3 cycles -> assembly matches input; out_data constant while stalled; no word lost or duplicated.
REQ-029 Key shift: key=163'h...0B, next_key for 4 cycles -> ki sequence 1,1,0,1 then 0.
REQ-030 Abort: abort at op_idx=2, word_idx=3 -> IDLE next cycle, busy=0; a new run then behaves exactly as REQ-027.
REQ-031 Reset in PROC: wb_rst_i for 1 cycle while master_ena_proc=1 -> next cycle state_o=0 and master_ena_proc=0, ki=0, load_status=0.
REQ-032 start pulsed in LOAD, PUSH, PROC, READ -> no effect on state or counters; slv_done and next_key asserted together -> READ entered, captured result = data_in.
